// File: rtl/motion_pkg.sv
// Shared types and default physics constants for the character motion controller.
// Latency: none (types and constants only).
// Backpressure: none.
package motion_pkg;

    // Default parameter values for character_motion_ctrl.
    localparam int DEF_CORDW       = 16;
    localparam int DEF_H_RES       = 800;
    localparam int DEF_SPR_W       = 19;
    localparam int DEF_SCALE_X     = 4;
    localparam int DEF_START_X     = 100;
    localparam int DEF_GROUND_Y    = 500;
    localparam int DEF_WALK_SPEED  = 3;
    localparam int DEF_JUMP_VEL    = 12;
    localparam int DEF_GRAVITY     = 1;
    localparam int DEF_MAX_FALL    = 16;
    localparam int DEF_LAND_FRAMES = 4;

    // Encoding is visible on o_state, so values are fixed.
    typedef enum logic [1:0] {
        GROUND = 2'd0,
        AIR    = 2'd1,
        LAND   = 2'd2
    } motion_state_t;

    typedef logic signed [DEF_CORDW-1:0] coord_t;

endpackage

// File: rtl/edge_latch.sv
// Rising-edge detector with a sticky request, cleared by a frame pulse.
// Latency: o_req is combinational on the edge cycle, then registered until cleared.
// Backpressure: none; an edge arriving on the clear cycle is consumed by that clear.
// Ports: i_clk/i_rst_n clock and async active-low reset, i_level button level,
//        i_clr consume/clear pulse, o_req pending request (including a same-cycle edge).
module edge_latch (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    input  logic i_clr,
    output logic o_req
);

    logic prev_q, prev_d;
    logic req_q,  req_d;
    logic rise;

    always_comb begin
        rise   = i_level & ~prev_q;
        // Fold the current-cycle edge into the request so a consumer sampling
        // on the clear cycle still sees it.
        o_req  = req_q | rise;
        prev_d = i_level;
        req_d  = i_clr ? 1'b0 : o_req;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            req_q  <= req_d;
        end
    end

endmodule

// File: rtl/character_motion_ctrl.sv
// Frame-synchronous sprite motion controller: buttons -> position, facing, animation flags.
// Latency: all registers update on the i_frame cycle; outputs valid the next cycle, held for the frame.
// Backpressure: none; button levels are sampled, jump edges are latched until the next frame.
// Ports: i_clk_pix/i_rst_n clock and async reset, i_frame vblank pulse, i_left/i_right/i_jump
//        synchronised button levels, o_sprx/o_spry sprite position, o_face_left/o_walking/o_jumping
//        renderer controls, o_state current FSM state.
module character_motion_ctrl
    import motion_pkg::*;
#(
    parameter int CORDW       = DEF_CORDW,
    parameter int H_RES       = DEF_H_RES,
    parameter int SPR_W       = DEF_SPR_W,
    parameter int SCALE_X     = DEF_SCALE_X,
    parameter int START_X     = DEF_START_X,
    parameter int GROUND_Y    = DEF_GROUND_Y,
    parameter int WALK_SPEED  = DEF_WALK_SPEED,
    parameter int JUMP_VEL    = DEF_JUMP_VEL,
    parameter int GRAVITY     = DEF_GRAVITY,
    parameter int MAX_FALL    = DEF_MAX_FALL,
    parameter int LAND_FRAMES = DEF_LAND_FRAMES
) (
    input  logic                    i_clk_pix,
    input  logic                    i_rst_n,
    input  logic                    i_frame,
    input  logic                    i_left,
    input  logic                    i_right,
    input  logic                    i_jump,
    output logic signed [CORDW-1:0] o_sprx,
    output logic signed [CORDW-1:0] o_spry,
    output logic                    o_face_left,
    output logic                    o_walking,
    output logic                    o_jumping,
    output logic [1:0]              o_state
);

    // One extra bit so x+dx and y-vy cannot wrap before clamping.
    localparam int WW  = CORDW + 1;
    localparam int LCW = (LAND_FRAMES > 1) ? $clog2(LAND_FRAMES) : 1;

    typedef logic signed [WW-1:0]    wide_t;
    typedef logic signed [CORDW-1:0] crd_t;

    localparam wide_t X_MAX    = wide_t'(H_RES - SPR_W * SCALE_X);
    localparam wide_t WALK     = wide_t'(WALK_SPEED);
    localparam wide_t GRAV     = wide_t'(GRAVITY);
    localparam wide_t MAXF     = wide_t'(MAX_FALL);
    localparam wide_t GROUND_W = wide_t'(GROUND_Y);
    localparam wide_t ZERO_W   = '0;
    localparam crd_t  X_RST    = crd_t'(START_X);
    localparam crd_t  Y_RST    = crd_t'(GROUND_Y);
    localparam crd_t  VY_JUMP  = crd_t'(JUMP_VEL);

    motion_state_t   state_q, state_d;
    crd_t            x_q, x_d;
    crd_t            y_q, y_d;
    crd_t            vy_q, vy_d;
    logic [LCW-1:0]  land_cnt_q, land_cnt_d;
    logic            face_q, face_d;
    logic            walk_q, walk_d;
    logic            jump_q, jump_d;

    logic            jump_req;
    wide_t           dx, x_sum, x_clamp;
    wide_t           y_sum, vy_dec;
    logic            vy_nonpos;

    edge_latch u_jump_latch (
        .i_clk   (i_clk_pix),
        .i_rst_n (i_rst_n),
        .i_level (i_jump),
        .i_clr   (i_frame),
        .o_req   (jump_req)
    );

    // State register (all per-frame state).
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= GROUND;
            x_q        <= X_RST;
            y_q        <= Y_RST;
            vy_q       <= '0;
            land_cnt_q <= '0;
            face_q     <= 1'b0;
            walk_q     <= 1'b0;
            jump_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            land_cnt_q <= land_cnt_d;
            face_q     <= face_d;
            walk_q     <= walk_d;
            jump_q     <= jump_d;
        end
    end

    // Next-state and vertical physics.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        vy_d       = vy_q;
        land_cnt_d = land_cnt_q;

        y_sum      = wide_t'(y_q) - wide_t'(vy_q);
        vy_dec     = wide_t'(vy_q) - GRAV;
        if (vy_dec < -MAXF) begin
            vy_dec = -MAXF;
        end
        vy_nonpos  = (wide_t'(vy_q) <= ZERO_W);

        if (i_frame) begin
            case (state_q)
                GROUND: begin
                    if (jump_req) begin
                        state_d = AIR;
                        vy_d    = VY_JUMP;
                    end
                end
                AIR: begin
                    if (y_sum[WW-1]) begin
                        // Head bump at the top of the screen: stop and fall from there.
                        y_d  = '0;
                        vy_d = '0;
                    end else if ((y_sum >= GROUND_W) && vy_nonpos) begin
                        y_d        = Y_RST;
                        vy_d       = '0;
                        state_d    = LAND;
                        land_cnt_d = LCW'(LAND_FRAMES - 1);
                    end else begin
                        y_d  = y_sum[CORDW-1:0];
                        vy_d = vy_dec[CORDW-1:0];
                    end
                end
                LAND: begin
                    if (land_cnt_q == '0) begin
                        state_d = GROUND;
                    end else begin
                        land_cnt_d = land_cnt_q - 1'b1;
                    end
                end
                default: state_d = GROUND;
            endcase
        end
    end

    // Horizontal movement and renderer flags.
    always_comb begin
        x_d    = x_q;
        face_d = face_q;
        walk_d = walk_q;
        jump_d = jump_q;

        dx = '0;
        if (i_right && !i_left) begin
            dx = WALK;
        end else if (i_left && !i_right) begin
            dx = -WALK;
        end
        x_sum = wide_t'(x_q) + dx;
        if (x_sum[WW-1]) begin
            x_clamp = '0;
        end else if (x_sum > X_MAX) begin
            x_clamp = X_MAX;
        end else begin
            x_clamp = x_sum;
        end

        if (i_frame) begin
            // Flags follow the state the sprite is entering, so o_jumping
            // is high exactly while o_state reads AIR.
            jump_d = (state_d == AIR);
            walk_d = 1'b0;
            if (state_q != LAND) begin
                if (dx > ZERO_W) begin
                    face_d = 1'b0;
                end else if (dx < ZERO_W) begin
                    face_d = 1'b1;
                end
                x_d = x_clamp[CORDW-1:0];
                // Walking only when x actually moved, so pushing into a wall stops the animation.
                walk_d = (state_d == GROUND) && (x_d != x_q);
            end
        end
    end

    assign o_sprx      = x_q;
    assign o_spry      = y_q;
    assign o_face_left = face_q;
    assign o_walking   = walk_q;
    assign o_jumping   = jump_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_character_motion_ctrl.sv
module tb_character_motion_ctrl;

    localparam int WS   = 3;
    localparam int JV   = 12;
    localparam int GR   = 1;
    localparam int MF   = 16;
    localparam int LF   = 4;
    localparam int XMAX = 800 - 19 * 4;
    localparam int GY   = 500;
    localparam int SX   = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame = 1'b0;
    logic left = 1'b0;
    logic right = 1'b0;
    logic jump = 1'b0;
    logic signed [15:0] sprx, spry;
    logic face, walking, jumping;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    // Reference model: one frame of character physics in plain integers.
    int m_x, m_y, m_vy, m_st, m_lc;
    bit m_face, m_walk, m_jmp, m_req, m_prev;

    always #5 clk = ~clk;

    character_motion_ctrl dut (
        .i_clk_pix   (clk),
        .i_rst_n     (rst_n),
        .i_frame     (frame),
        .i_left      (left),
        .i_right     (right),
        .i_jump      (jump),
        .o_sprx      (sprx),
        .o_spry      (spry),
        .o_face_left (face),
        .o_walking   (walking),
        .o_jumping   (jumping),
        .o_state     (state)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"},     sprx,    m_x);
        chk({tag, ".y"},     spry,    m_y);
        chk({tag, ".face"},  face,    int'(m_face));
        chk({tag, ".walk"},  walking, int'(m_walk));
        chk({tag, ".jump"},  jumping, int'(m_jmp));
        chk({tag, ".state"}, state,   m_st);
    endtask

    task automatic model_reset();
        m_x = SX; m_y = GY; m_vy = 0; m_st = 0; m_lc = 0;
        m_face = 0; m_walk = 0; m_jmp = 0; m_req = 0; m_prev = 0;
    endtask

    task automatic model_step(input bit l, input bit r);
        int dx, nx, ny, old;
        bit moved;
        old = m_st;
        moved = 0;
        dx = (r && !l) ? WS : ((l && !r) ? -WS : 0);
        if (old != 2) begin
            if (dx > 0) m_face = 0;
            else if (dx < 0) m_face = 1;
            nx = m_x + dx;
            if (nx < 0) nx = 0;
            if (nx > XMAX) nx = XMAX;
            moved = (nx != m_x);
            m_x = nx;
        end
        case (old)
            0: if (m_req) begin m_st = 1; m_vy = JV; end
            1: begin
                ny = m_y - m_vy;
                if (ny < 0) begin
                    m_y = 0; m_vy = 0;
                end else if (ny >= GY && m_vy <= 0) begin
                    m_y = GY; m_vy = 0; m_st = 2; m_lc = LF - 1;
                end else begin
                    m_y = ny;
                    m_vy = (m_vy - GR < -MF) ? -MF : m_vy - GR;
                end
            end
            2: if (m_lc == 0) m_st = 0; else m_lc--;
            default: m_st = 0;
        endcase
        m_req  = 0;
        m_jmp  = (m_st == 1);
        m_walk = (m_st == 0) && moved;
    endtask

    // One frame: jump level jm mid-frame, jf on the frame-pulse cycle.
    task automatic run_frame(input bit l, input bit r, input bit jm, input bit jf);
        @(negedge clk);
        left = l; right = r; jump = jm;
        if (jm && !m_prev) m_req = 1;
        m_prev = jm;
        repeat (3) @(negedge clk);
        chk("hold.x", sprx, m_x);
        chk("hold.state", state, m_st);
        jump = jf; frame = 1'b1;
        if (jf && !m_prev) m_req = 1;
        m_prev = jf;
        @(negedge clk);
        frame = 1'b0;
        model_step(l, r);
        check_all("frame");
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        repeat (10) run_frame(0, 0, 0, 0);
        chk("idle.x", sprx, 100);
        chk("idle.state", state, 0);

        repeat (5) run_frame(0, 1, 0, 0);
        chk("right5.x", sprx, 115);
        chk("right5.walk", walking, 1);
        run_frame(0, 0, 0, 0);
        chk("release.walk", walking, 0);
        chk("release.x", sprx, 115);

        repeat (45) run_frame(1, 0, 0, 0);
        chk("lwall.x", sprx, 0);
        chk("lwall.face", face, 1);
        chk("lwall.walk", walking, 0);

        repeat (260) run_frame(0, 1, 0, 0);
        chk("rwall.x", sprx, XMAX);
        chk("rwall.walk", walking, 0);

        // Jump edge mid-frame, released before the frame pulse.
        run_frame(0, 0, 1, 0);
        chk("takeoff.state", state, 1);
        chk("takeoff.y", spry, 500);
        repeat (12) run_frame(0, 0, 0, 0);
        chk("apex.y", spry, 422);
        repeat (13) run_frame(0, 0, 0, 0);
        chk("touch.y", spry, 500);
        chk("touch.state", state, 2);
        chk("touch.jump", jumping, 0);
        repeat (3) run_frame(0, 0, 0, 0);
        chk("land4.state", state, 2);
        run_frame(0, 0, 0, 0);
        chk("ground.state", state, 0);

        // Jump held through the whole arc: exactly one jump.
        repeat (45) run_frame(0, 0, 1, 1);
        chk("held.state", state, 0);
        run_frame(0, 0, 0, 0);
        run_frame(0, 0, 1, 1);
        chk("repress.state", state, 1);
        repeat (40) run_frame(0, 0, 0, 0);

        // Edge on the frame cycle with both directions pressed.
        run_frame(1, 1, 0, 1);
        chk("coinc.state", state, 1);
        repeat (5) run_frame(1, 1, 1, 1);
        chk("mid.y", spry, 450);

        // Asynchronous reset mid-air, checked before the next rising edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0; jump = 1'b0; left = 1'b0; right = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            run_frame($urandom_range(0, 1), $urandom_range(0, 1),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/character_motion_ctrl.md
Name: character_motion_ctrl

Overview:
- Frame-synchronous motion controller for one on-screen character sprite.
- Converts player button levels into sprite position (x, y) and animation controls (face-left, walking, jumping) for the moving-sprite renderer.
- Runs a ground/air/land state machine with integer walk speed, jump velocity, gravity and screen clamping.
- Sits between the input synchronisers and the sprite renderer; all outputs change only once per video frame.

Parameters:
- CORDW, 16, signed coordinate width
- H_RES, 800, horizontal active pixels
- SPR_W, 19, unscaled sprite width (pixels)
- SCALE_X, 4, horizontal scale factor applied by renderer
- START_X, 100, reset x position
- GROUND_Y, 500, y of sprite top when standing
- WALK_SPEED, 3, pixels per frame horizontally
- JUMP_VEL, 12, initial upward velocity (pixels/frame)
- GRAVITY, 1, velocity decrement per airborne frame
- MAX_FALL, 16, maximum downward speed (pixels/frame)
- LAND_FRAMES, 4, frames held in LAND after touchdown

Ports:
- i_clk_pix  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame  in  1  one-cycle pulse at start of vertical blank
- i_left  in  1  left button level, already synchronised
- i_right  in  1  right button level, already synchronised
- i_jump  in  1  jump button level, already synchronised
- o_sprx  out  CORDW signed  sprite left x
- o_spry  out  CORDW signed  sprite top y
- o_face_left  out  1  sprite mirrored
- o_walking  out  1  walk animation enable
- o_jumping  out  1  jump animation enable
- o_state  out  2  current FSM state, for debug/score logic

Behaviour:
- Clock and reset: one clock i_clk_pix; reset i_rst_n is asynchronous, active-low.
- Reset values: o_sprx=START_X, o_spry=GROUND_Y, o_face_left=0, o_walking=0, o_jumping=0, state=GROUND, vy=0, jump_req=0, land_cnt=0.
- Jump request latch:
  - jump_req is set on any rising edge of i_jump, sampled every clock (previous-level register).
  - jump_req is cleared on i_frame.
  - If the edge and i_frame coincide, the request is consumed at that frame.
  - Holding i_jump does not re-trigger a jump.
- Update timing:
  - All state, position and output registers update only in the cycle where i_frame=1.
  - Outputs are valid the next cycle and held stable for the rest of the frame (1-cycle latency).
- Horizontal movement, evaluated on i_frame in every state except LAND:
  - right & ~left: dx=+WALK_SPEED, o_face_left<=0.
  - left & ~right: dx=-WALK_SPEED, o_face_left<=1.
  - Neither or both pressed: dx=0, facing unchanged.
  - x_next = x+dx, clamped to [0, H_RES-SPR_W*SCALE_X]; compute in CORDW+1 bits before clamping.
- FSM states: GROUND=0, AIR=1, LAND=2 (3 unused, returns to GROUND).
- GROUND:
  - jump_req → AIR, vy<=JUMP_VEL, no y change this frame.
  - Otherwise stay in GROUND.
  - o_walking<=(dx!=0) (also 0 when clamped at edge and x unchanged); o_jumping<=0.
- AIR (vy signed, positive = upward):
  - y_next=y-vy; vy_next=max(vy-GRAVITY, -MAX_FALL).
  - If y_next<0: y<=0, vy<=0 (head bump), stay in AIR.
  - Else if y_next>=GROUND_Y and vy<=0: y<=GROUND_Y, vy<=0, →LAND, land_cnt<=LAND_FRAMES-1.
  - Else y<=y_next, vy<=vy_next.
  - o_jumping<=1, o_walking<=0.
  - jump_req is ignored (no double jump).
- LAND:
  - x frozen, o_walking<=0, o_jumping<=0.
  - land_cnt decrements each frame; at 0 → GROUND.
  - jump_req is ignored.
- Reset mid-jump: immediate return to reset values, no frame wait.

Decomposition:
- Package motion_pkg: state enum motion_state_t {GROUND, AIR, LAND}, typedef coord_t (signed CORDW), default physics constants.
- Sub-module edge_latch: rising-edge detect plus sticky request, cleared by i_frame. Reused for future fire/action buttons.

Test Plan:
- Reset with no input → o_sprx=100, o_spry=500, all flags 0, o_state=0 held across 10 frames.
- i_right held 5 frames → o_sprx=115, o_walking=1, o_face_left=0; release → o_walking=0 next frame, x stays 115.
- i_left held from x=2 → x clamps to 0 after 1 frame, o_face_left=1, o_walking=0 once x stops changing; i_right held at x=724 (800-76) → x stays 724.
- i_jump pulsed 1 cycle mid-frame → next frame AIR, vy=12:
  - y after frames 1..12 reaches 422 at apex (78 px rise).
  - Lands at y=500 on the 25th airborne frame.
  - Then LAND for 4 frames, then GROUND.
  - o_jumping=1 only during AIR.
- i_jump held through the whole jump and landing → exactly one jump; no re-jump until release and re-press after GROUND.
- i_jump edge coinciding with i_frame, and i_left&i_right both pressed → jump starts this frame, dx=0, facing unchanged.
- i_rst_n asserted mid-air at y=450 → outputs return to reset values asynchronously, before the next clock edge.
